// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module  : nibble_serial_adder
// Brief   : WIDTH-bit adder evaluated one nibble per clock through a single
//           4-bit look-ahead carry slice, with valid/ready on both sides.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             carry_out
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;

    logic [3:0]         w_a4;
    logic [3:0]         w_b4;
    logic [3:0]         w_p;
    logic [3:0]         w_g;
    logic [3:0]         w_c;
    logic               w_c4;
    logic [3:0]         w_sum4;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign s         = r_s;
    assign carry_out = r_cout;

    // Operand nibble selected by the slice index (constant-index mux).
    always_comb begin
        w_a4 = 4'd0;
        w_b4 = 4'd0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a4 = r_a[4*k +: 4];
                w_b4 = r_b[4*k +: 4];
            end
        end
    end

    // Carries expanded from generate/propagate terms so none ripple.
    always_comb begin
        w_p    = w_a4 ^ w_b4;
        w_g    = w_a4 & w_b4;
        w_c[0] = r_carry;
        w_c[1] = w_g[0] | (w_p[0] & r_carry);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_c4   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_sum4 = w_p ^ w_c;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)              w_next = S_RUN;
            S_RUN:   if (r_idx == C_LAST_IDX)   w_next = S_DONE;
            S_DONE:  if (out_ready)             w_next = S_IDLE;
            default:                            w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_s     <= '0;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            r_s[4*k +: 4] <= w_sum4;
                        end
                    end
                    r_carry <= w_c4;
                    if (r_idx == C_LAST_IDX) begin
                        r_cout <= w_c4;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module  : tb_nibble_serial_adder
// Brief   : Self-checking bench for nibble_serial_adder (WIDTH=16).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             carry_out;

    int n_tests = 0;
    int n_fail  = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // Reference: plain wide addition.
    function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation, waits for acceptance, returns cycles until out_valid.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tc, output int lat);
        int guard;
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (s !== '0) begin n_fail++; $display("FAIL reset_s got %h want 0000", s); end
        n_tests++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", carry_out); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [3] = '{16'hFFFF, 16'h1234, 16'h0000};
        logic [WIDTH-1:0] vb [3] = '{16'h0001, 16'h4321, 16'h0000};
        logic             vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [WIDTH:0]   exp;
        int lat;
        for (int i = 0; i < 3; i++) begin
            exp = model_add(va[i], vb[i], vc[i]);
            do_op(va[i], vb[i], vc[i], lat);
            n_tests++; if (lat !== N) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, N); end
            n_tests++; if ({carry_out, s} !== exp) begin n_fail++; $display("FAIL dir%0d_result got %b_%h want %b_%h", i, carry_out, s, exp[WIDTH], exp[WIDTH-1:0]); end
            release_op();
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_ready_after got %b want 1", i, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(16'h8000, 16'h8000, 1'b0, lat);
        n_tests++; if (lat !== N) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, N); end
        a = 16'h0001; b = 16'h0000; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if ({out_valid, carry_out, s, in_ready} !== {1'b1, 1'b1, 16'h0000, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%b c=%b s=%h r=%b want v=1 c=1 s=0000 r=0", i, out_valid, carry_out, s, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        release_op();
        n_tests++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int guard;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin tick(); guard++; end
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if ({in_ready, out_valid, carry_out, s} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++; $display("FAIL midrun_reset got r=%b v=%b c=%b s=%h want r=1 v=0 c=0 s=0000", in_ready, out_valid, carry_out, s);
        end
        do_op(16'h00FF, 16'h0001, 1'b0, lat);
        n_tests++; if (lat !== N) begin n_fail++; $display("FAIL midrun_latency got %0d want %0d", lat, N); end
        n_tests++; if ({carry_out, s} !== {1'b0, 16'h0100}) begin n_fail++; $display("FAIL midrun_result got %b_%h want 0_0100", carry_out, s); end
        release_op();
    endtask

    task automatic test_back_to_back();
        int             acc_n;
        int             done_n;
        int             acc_t [2];
        logic [WIDTH:0] got [2];
        logic [WIDTH:0] exp [2];
        logic           acc;
        logic           dn;
        exp[0] = model_add(16'hABCD, 16'h1111, 1'b0);
        exp[1] = model_add(16'hF0F0, 16'h0F10, 1'b0);
        acc_n = 0; done_n = 0; acc_t[0] = 0; acc_t[1] = 0; got[0] = '0; got[1] = '0;
        a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && done_n < 2; cyc++) begin
            acc = in_valid & in_ready;
            dn  = out_valid & out_ready;
            if (dn) begin got[done_n] = {carry_out, s}; done_n++; end
            tick();
            if (acc && acc_n < 2) begin acc_t[acc_n] = cyc; acc_n++; end
            if (out_valid) begin
                if (acc_n == 1) begin a = 16'hF0F0; b = 16'h0F10; cin = 1'b0; end
                else in_valid = 1'b0;
            end else if (!in_ready) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_tests++; if (acc_n !== 2 || done_n !== 2) begin n_fail++; $display("FAIL b2b_count got acc=%0d done=%0d want 2 2", acc_n, done_n); end
        n_tests++; if (acc_t[1] - acc_t[0] !== N + 2) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", acc_t[1] - acc_t[0], N + 2); end
        for (int i = 0; i < 2; i++) begin
            n_tests++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_result%0d got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic [WIDTH:0]   exp;
        int lat;
        for (int i = 0; i < 25; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
            exp = model_add(ra, rb, rc);
            do_op(ra, rb, rc, lat);
            n_tests++; if (lat !== N) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, N); end
            n_tests++; if ({carry_out, s} !== exp) begin n_fail++; $display("FAIL rnd%0d_result a=%h b=%h c=%b got %b_%h want %b_%h", i, ra, rb, rc, carry_out, s, exp[WIDTH], exp[WIDTH-1:0]); end
            release_op();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder. It adds two operands four bits per clock by driving a 4-bit look-ahead carry slice, and it chains the slice carry-out back as the next slice's carry-in through a register. It sits in the datapath between an operand producer and a result consumer, using valid/ready handshakes on both sides. It trades latency for area: one 4-bit look-ahead slice serves any operand width.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- N (derived, not overridable) = WIDTH/4, number of slice cycles.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a, b, cin.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  s/carry_out hold a finished result.
- out_ready  in  1  downstream accepts the result.
- s  out  WIDTH  sum a+b+cin, modulo 2^WIDTH.
- carry_out  out  1  carry out of bit WIDTH-1.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- Registers: a_q, b_q (WIDTH), carry_q (1), idx (ceil(log2 N), min 1 bit), s (WIDTH), carry_out.
- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch a_q<=a, b_q<=b, carry_q<=cin, idx<=0, s<=0, then go to RUN.
- RUN
  - in_ready=0, out_valid=0.
  - Each cycle, the slice computes {c4, sum4} = a_q[4*idx+:4] + b_q[4*idx+:4] + carry_q using look-ahead terms p=a^b, g=a&b (c1..c4 from p/g/carry_q, not rippled).
  - s[4*idx+:4]<=sum4 and carry_q<=c4.
  - If idx==N-1: carry_out<=c4 and go to DONE. Otherwise idx<=idx+1.
- DONE
  - out_valid=1; s and carry_out are held stable.
  - On out_ready go to IDLE. Otherwise stay.
- in_valid is ignored outside IDLE. Changes on a/b/cin after acceptance have no effect.
- out_ready is ignored outside DONE.
- Arithmetic is unsigned modulo 2^WIDTH. {carry_out, s} equals a+b+cin exactly. No signed overflow flag.

## Timing
- Reset (rst=1 at a rising edge), from any state including mid-RUN or DONE:
  - state<=IDLE.
  - s=0, carry_out=0, out_valid=0.
  - in_ready=1 from the cycle after reset.
  - Any in-flight operation is discarded with no output.
- in_ready and out_valid are decoded from state only (registered state, no combinational path from in_valid/out_ready).
- Latency: acceptance at edge T gives out_valid=1 in the cycle after edge T+N (N RUN cycles). For WIDTH=16, out_valid rises 4 cycles after acceptance.
- Throughput: with out_ready held high, one operation every N+2 cycles (accept, N RUN cycles, 1 DONE cycle, then IDLE).
- Result handshake completes at the edge where out_valid & out_ready. in_ready=1 in the following cycle.
- During RUN, s bits above 4*idx are 0 and bits below are final partial sums. s is only meaningful while out_valid=1.
- The carry chain crosses slice boundaries only through carry_q: one register stage per nibble, and the critical path is one 4-bit look-ahead slice.
- N=1 (WIDTH=4): a single RUN cycle, then DONE.

## Test plan
- Carry across the full width: WIDTH=16, a=0xFFFF, b=0x0001, cin=0.
  - out_valid exactly 4 cycles after accept.
  - s=0x0000, carry_out=1.
- Carry-in only: a=0x1234, b=0x4321, cin=1 → s=0x5556, carry_out=0.
- Zero operands: a=0x0000, b=0x0000, cin=1 → s=0x0001, carry_out=0.
- Backpressure: a=0x8000, b=0x8000, cin=0, out_ready held low 5 cycles after out_valid.
  - s=0x0000, carry_out=1 stable throughout; in_ready=0.
  - A new in_valid with a=0x0001 is ignored.
  - out_ready=1 → in_ready=1 next cycle.
- Reset mid-RUN: assert rst on the 2nd RUN cycle.
  - Next cycle: in_ready=1, out_valid=0, s=0, carry_out=0.
  - A new operation 0x00FF+0x0001 yields s=0x0100, carry_out=0.
- Back-to-back and operand stability: with out_ready high, issue 0xABCD+0x1111 then 0xF0F0+0x0F10, changing a/b on every RUN cycle.
  - Results: s=0xBCDE, carry_out=0, then s=0x0000, carry_out=1.
  - Accepts are N+2=6 cycles apart.
